riscv_priv_dbg_ctrl: RTL and testbench

//  Owns the hart privilege level and gates debug-mode entry behind key authentication.

---
 rtl/riscv_priv_dbg_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_riscv_priv_dbg_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_priv_dbg_ctrl.sv
// Hart privilege register plus key-authenticated debug entry FSM (RUN/AUTH/DEBUG/LOCKED).
// Optional lockout after repeated failed authentications: define RISCV_DBG_LOCKOUT_EN.
module riscv_priv_dbg_ctrl #(
  parameter int unsigned           DBG_KEY_W      = 32,
  parameter logic [DBG_KEY_W-1:0]  DBG_KEY        = 32'hA5C30F1E,
  parameter int unsigned           AUTH_TIMEOUT   = 256,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trap_valid_i,
  input  logic                 trap_to_super_i,
  input  logic                 xret_valid_i,
  input  logic                 xret_is_mret_i,
  input  logic [1:0]           xret_target_i,
  input  logic                 dbg_req_i,
  input  logic                 dbg_key_valid_i,
  input  logic [DBG_KEY_W-1:0] dbg_key_i,
  input  logic                 dbg_exit_i,
  output logic [1:0]           priv_o,
  output logic                 supervisor_o,
  output logic                 dbg_mode_o,
  output logic                 dbg_ack_o,
  output logic                 dbg_nack_o,
  output logic                 dbg_locked_o
);

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int unsigned   TW      = $clog2(AUTH_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(AUTH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_AUTH   = 2'd1,
    ST_DEBUG  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    priv_q, priv_d;
  logic          sup_q, sup_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          key_ok;
  logic          xret_legal;
  logic [1:0]    xret_priv;

`ifdef RISCV_DBG_LOCKOUT_EN
  localparam int unsigned   FW        = $clog2(MAX_FAILS + 1);
  localparam int unsigned   LW        = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_FAILS == 0) ^ (LOCKOUT_CYCLES == 0);
`endif

  assign key_ok = dbg_key_valid_i && (dbg_key_i == DBG_KEY);

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      to_cnt_q   <= '0;
      priv_q     <= PRIV_M;
      sup_q      <= 1'b0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
`ifdef RISCV_DBG_LOCKOUT_EN
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      priv_q     <= priv_d;
      sup_q      <= sup_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
`ifdef RISCV_DBG_LOCKOUT_EN
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Next-state logic; a key arriving on the timeout cycle is still evaluated first
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
`ifdef RISCV_DBG_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
        to_cnt_d = '0;
        if (dbg_req_i) begin
          state_d = ST_AUTH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_AUTH: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (key_ok) begin
          state_d = ST_DEBUG;
          ack_d   = 1'b1;
`ifdef RISCV_DBG_LOCKOUT_EN
          fail_cnt_d = '0;
`endif
        end else if (dbg_key_valid_i || (to_cnt_q == TO_LAST)) begin
          state_d = ST_RUN;
          nack_d  = 1'b1;
`ifdef RISCV_DBG_LOCKOUT_EN
          fail_cnt_d = fail_cnt_q + FW'(1);
          if (fail_cnt_d >= FAIL_MAX) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = '0;
          end else begin
            state_d = ST_RUN;
          end
`endif
        end else begin
          state_d = ST_AUTH;
        end
      end
      ST_DEBUG: begin
        if (dbg_exit_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DEBUG;
        end
      end
      ST_LOCKED: begin
`ifdef RISCV_DBG_LOCKOUT_EN
        lock_cnt_d = lock_cnt_q + LW'(1);
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_RUN;
          fail_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          state_d = ST_LOCKED;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Return legality and reserved-target mapping for mret/sret
  always_comb begin
    if (xret_is_mret_i) begin
      xret_legal = (priv_q == PRIV_M);
    end else begin
      xret_legal = (priv_q == PRIV_S) || (priv_q == PRIV_M);
    end
    if (xret_target_i == 2'b10) begin
      xret_priv = PRIV_U;
    end else begin
      xret_priv = xret_target_i;
    end
  end

  // Privilege update; the hart is halted in DEBUG so trap/xret are dropped there
  always_comb begin
    priv_d = priv_q;
    if (state_q == ST_DEBUG) begin
      priv_d = priv_q;
    end else if (trap_valid_i) begin
      if (trap_to_super_i && (priv_q != PRIV_M)) begin
        priv_d = PRIV_S;
      end else begin
        priv_d = PRIV_M;
      end
    end else if (xret_valid_i && xret_legal) begin
      priv_d = xret_priv;
    end else begin
      priv_d = priv_q;
    end
    sup_d = (priv_d == PRIV_S);
  end

  // Output decode from registered state
  always_comb begin
    dbg_mode_o   = (state_q == ST_DEBUG);
`ifdef RISCV_DBG_LOCKOUT_EN
    dbg_locked_o = (state_q == ST_LOCKED);
`else
    dbg_locked_o = 1'b0;
`endif
  end

  assign priv_o       = priv_q;
  assign supervisor_o = sup_q;
  assign dbg_ack_o    = ack_q;
  assign dbg_nack_o   = nack_q;

endmodule

// File: tb/tb_riscv_priv_dbg_ctrl.sv
// Self-checking bench for riscv_priv_dbg_ctrl: vector table through a scoreboard queue,
// plus hand sequences for timeout, key-on-timeout, mid-AUTH reset and (if built) lockout.
module tb_riscv_priv_dbg_ctrl;

  localparam logic [31:0] KEY = 32'hA5C30F1E;
  localparam logic [31:0] BAD = 32'h12345678;

  typedef struct {
    logic        trap, tsup, xv, mret;
    logic [1:0]  tgt;
    logic        req, kv;
    logic [31:0] key;
    logic        ex;
    logic [1:0]  e_priv;
    logic        e_sup, e_mode, e_ack, e_nack, e_lock;
  } vec_t;

  logic        clk, rst;
  logic        trap_valid, trap_to_super, xret_valid, xret_is_mret;
  logic [1:0]  xret_target;
  logic        dbg_req, dbg_key_valid, dbg_exit;
  logic [31:0] dbg_key;
  logic [1:0]  priv_o;
  logic        supervisor_o, dbg_mode_o, dbg_ack_o, dbg_nack_o, dbg_locked_o;

  int    checks = 0;
  int    errors = 0;
  string tag;
  vec_t  exp_q[$];
  vec_t  tbl[$];

  riscv_priv_dbg_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .trap_valid_i   (trap_valid),
    .trap_to_super_i(trap_to_super),
    .xret_valid_i   (xret_valid),
    .xret_is_mret_i (xret_is_mret),
    .xret_target_i  (xret_target),
    .dbg_req_i      (dbg_req),
    .dbg_key_valid_i(dbg_key_valid),
    .dbg_key_i      (dbg_key),
    .dbg_exit_i     (dbg_exit),
    .priv_o         (priv_o),
    .supervisor_o   (supervisor_o),
    .dbg_mode_o     (dbg_mode_o),
    .dbg_ack_o      (dbg_ack_o),
    .dbg_nack_o     (dbg_nack_o),
    .dbg_locked_o   (dbg_locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic trap, tsup, xv, mret, input logic [1:0] tgt,
                              input logic req, kv, input logic [31:0] key, input logic ex,
                              input logic [1:0] ep, input logic es, em, ea, en);
    vec_t v;
    v.trap = trap; v.tsup = tsup; v.xv = xv; v.mret = mret; v.tgt = tgt;
    v.req = req; v.kv = kv; v.key = key; v.ex = ex;
    v.e_priv = ep; v.e_sup = es; v.e_mode = em; v.e_ack = ea; v.e_nack = en;
    v.e_lock = 1'b0;
    return v;
  endfunction

  function automatic vec_t idle(input logic [1:0] ep, input logic es, em);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, ep, es, em, 1'b0, 1'b0);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    trap_valid = 1'b0; trap_to_super = 1'b0; xret_valid = 1'b0; xret_is_mret = 1'b0;
    xret_target = 2'd0; dbg_req = 1'b0; dbg_key_valid = 1'b0; dbg_key = 32'd0;
    dbg_exit = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    trap_valid = v.trap; trap_to_super = v.tsup; xret_valid = v.xv; xret_is_mret = v.mret;
    xret_target = v.tgt; dbg_req = v.req; dbg_key_valid = v.kv; dbg_key = v.key;
    dbg_exit = v.ex;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp("priv", {30'd0, priv_o}, {30'd0, e.e_priv});
    cmp("sup", {31'd0, supervisor_o}, {31'd0, e.e_sup});
    cmp("mode", {31'd0, dbg_mode_o}, {31'd0, e.e_mode});
    cmp("ack", {31'd0, dbg_ack_o}, {31'd0, e.e_ack});
    cmp("nack", {31'd0, dbg_nack_o}, {31'd0, e.e_nack});
    cmp("locked", {31'd0, dbg_locked_o}, {31'd0, e.e_lock});
    clear_inputs();
  endtask

  initial begin
    int   n;
    logic bad;
    vec_t v;

    //           trap tsup xv   mret tgt   req  kv   key  ex    priv  sup  mode ack  nack
    tbl.push_back(idle(2'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, BAD,   1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(idle(2'd0, 1'b0, 1'b0));
    tbl.push_back(idle(2'd0, 1'b0, 1'b0));
    tbl.push_back(idle(2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, KEY,   1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, BAD,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(idle(2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, KEY,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, KEY,   1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tag = "reset";
    cmp("priv", {30'd0, priv_o}, 32'd3);
    cmp("sup", {31'd0, supervisor_o}, 32'd0);
    cmp("mode", {31'd0, dbg_mode_o}, 32'd0);
    cmp("ack", {31'd0, dbg_ack_o}, 32'd0);
    cmp("nack", {31'd0, dbg_nack_o}, 32'd0);
    cmp("locked", {31'd0, dbg_locked_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("row%0d", i);
      apply(tbl[i]);
    end

    // Timeout: nack exactly AUTH_TIMEOUT cycles after the request edge
    tag = "timeout";
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    n = 0;
    while (!dbg_nack_o && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    cmp("nack_latency", n, 32'd256);
    cmp("ack_with_nack", {31'd0, dbg_ack_o}, 32'd0);
    tag = "timeout_after";
    apply(idle(2'd0, 1'b0, 1'b0));

    // Key presented on the timeout cycle wins
    tag = "key_on_timeout";
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 255; i++) apply(idle(2'd0, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, KEY, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset while in AUTH returns to RUN: a following key is ignored
    tag = "rst_mid_auth";
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("priv", {30'd0, priv_o}, 32'd3);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, KEY, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));

`ifdef RISCV_DBG_LOCKOUT_EN
    // Three consecutive failures lock debug out for LOCKOUT_CYCLES cycles
    for (int i = 0; i < 3; i++) begin
      tag = $sformatf("lock_fail%0d", i);
      apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
      v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, BAD, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      v.e_lock = (i == 2);
      apply(v);
    end
    tag = "lockout";
    n = 0;
    bad = 1'b0;
    while (dbg_locked_o && n < 2000) begin
      n++;
      if (dbg_mode_o || dbg_ack_o) bad = 1'b1;
      dbg_req = 1'b1;
      @(posedge clk);
      #1;
    end
    dbg_req = 1'b0;
    cmp("locked_cycles", n, 32'd1024);
    cmp("req_ignored", {31'd0, bad}, 32'd0);
    apply(idle(2'd3, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, KEY, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
